// File: rtl/gat_pkg.sv
// Shared types and helpers for the GAT BRAM load/readout sequencer.
package gat_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LD_HDATA = 4'd1,
        ST_LD_NINFO = 4'd2,
        ST_LD_WGT   = 4'd3,
        ST_LD_SUBG  = 4'd4,
        ST_WAIT_GAT = 4'd5,
        ST_RD_ADDR  = 4'd6,
        ST_RD_WAIT  = 4'd7,
        ST_RD_OUT   = 4'd8
    } load_state_t;

    // Load phase indices; the first three also index the load_done flags.
    localparam int unsigned PH_HDATA = 0;
    localparam int unsigned PH_NINFO = 1;
    localparam int unsigned PH_WGT   = 2;
    localparam int unsigned PH_SUBG  = 3;
    localparam int unsigned NUM_PH   = 4;
    localparam int unsigned NUM_DONE = 3;

    function automatic int addr_w_f(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gat_bram_wr_port.sv
// One BRAM write port: turns the phase enable, stream handshake and shared word
// counter into din/ena/wea/addra, and flags the final word of the phase.
module gat_bram_wr_port
    import gat_pkg::*;
#(
    parameter int TOP_WIDTH = 32,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2,
    parameter int CNT_W     = 2
) (
    input  logic                 phase_en_i,
    input  logic                 wr_i,
    input  logic [CNT_W-1:0]     cnt_i,
    input  logic [TOP_WIDTH-1:0] data_i,
    output logic [TOP_WIDTH-1:0] din_o,
    output logic                 ena_o,
    output logic                 wea_o,
    output logic [ADDR_W+1:0]    addra_o,
    output logic                 last_o
);

    logic we_s;

    assign we_s = phase_en_i & wr_i;

    // Port is idle (all zero) whenever this phase is not writing.
    always_comb begin
        din_o   = {TOP_WIDTH{1'b0}};
        ena_o   = 1'b0;
        wea_o   = 1'b0;
        addra_o = {(ADDR_W + 2){1'b0}};
        last_o  = 1'b0;
        if (we_s) begin
            din_o   = data_i;
            ena_o   = 1'b1;
            wea_o   = 1'b1;
            addra_o = {cnt_i[ADDR_W-1:0], 2'b00};
            last_o  = (cnt_i == CNT_W'(DEPTH - 1));
        end else begin
            last_o  = 1'b0;
        end
    end

endmodule

// File: rtl/gat_bram_load_sched.sv
// Host-side sequencer: scatters one word stream into the four GAT input BRAMs,
// waits for the core, then streams the NEW_FEATURE BRAM back out.
module gat_bram_load_sched
    import gat_pkg::*;
#(
    parameter int TOP_WIDTH          = 32,
    parameter int H_DATA_DEPTH       = 242101,
    parameter int NODE_INFO_DEPTH    = 13264,
    parameter int WEIGHT_DEPTH       = 22928,
    parameter int SUBGRAPH_IDX_DEPTH = 13264,
    parameter int NEW_FEATURE_DEPTH  = 43328,
    localparam int H_DATA_ADDR_W       = addr_w_f(H_DATA_DEPTH),
    localparam int NODE_INFO_ADDR_W    = addr_w_f(NODE_INFO_DEPTH),
    localparam int WEIGHT_ADDR_W       = addr_w_f(WEIGHT_DEPTH),
    localparam int SUBGRAPH_IDX_ADDR_W = addr_w_f(SUBGRAPH_IDX_DEPTH),
    localparam int NEW_FEATURE_ADDR_W  = addr_w_f(NEW_FEATURE_DEPTH),
    localparam int CNT_W = addr_w_f(max_f(max_f(max_f(H_DATA_DEPTH, NODE_INFO_DEPTH),
                                                max_f(WEIGHT_DEPTH, SUBGRAPH_IDX_DEPTH)),
                                          NEW_FEATURE_DEPTH))
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_start,
    input  logic                           cfg_abort,
    input  logic [TOP_WIDTH-1:0]           s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [TOP_WIDTH-1:0]           h_data_bram_din,
    output logic                           h_data_bram_ena,
    output logic                           h_data_bram_wea,
    output logic [H_DATA_ADDR_W+1:0]       h_data_bram_addra,
    output logic [TOP_WIDTH-1:0]           h_node_info_bram_din,
    output logic                           h_node_info_bram_ena,
    output logic                           h_node_info_bram_wea,
    output logic [NODE_INFO_ADDR_W+1:0]    h_node_info_bram_addra,
    output logic [TOP_WIDTH-1:0]           wgt_bram_din,
    output logic                           wgt_bram_ena,
    output logic                           wgt_bram_wea,
    output logic [WEIGHT_ADDR_W+1:0]       wgt_bram_addra,
    output logic [TOP_WIDTH-1:0]           subgraph_bram_din,
    output logic                           subgraph_bram_ena,
    output logic                           subgraph_bram_wea,
    output logic [SUBGRAPH_IDX_ADDR_W+1:0] subgraph_bram_addra,
    output logic                           h_data_bram_load_done,
    output logic                           h_node_info_bram_load_done,
    output logic                           wgt_bram_load_done,
    input  logic                           gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0]  feat_bram_addrb,
    input  logic [TOP_WIDTH-1:0]           feat_bram_dout,
    output logic [TOP_WIDTH-1:0]           m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_last,
    output logic                           busy,
    output logic                           run_done
);

    load_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       rcnt_q, rcnt_d;
    logic [NUM_DONE-1:0]    done_q, done_d;
    logic                   gat_ready_q;
    logic [TOP_WIDTH-1:0]   m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_last_q, m_last_d;
    logic                   run_done_q, run_done_d;

    logic [NUM_PH-1:0]      ph_en_s;
    logic [NUM_PH-1:0]      wr_last_s;
    logic                   wr_s;
    logic                   gat_rise_s;
    logic                   rd_last_s;

    assign ph_en_s[PH_HDATA] = (state_q == ST_LD_HDATA);
    assign ph_en_s[PH_NINFO] = (state_q == ST_LD_NINFO);
    assign ph_en_s[PH_WGT]   = (state_q == ST_LD_WGT);
    assign ph_en_s[PH_SUBG]  = (state_q == ST_LD_SUBG);

    // Abort wins over a coincident handshake, so it also withdraws s_ready.
    assign s_ready    = (|ph_en_s) & ~cfg_abort;
    assign wr_s       = s_valid & s_ready;
    assign gat_rise_s = gat_ready & ~gat_ready_q;
    assign rd_last_s  = (rcnt_q == CNT_W'(NEW_FEATURE_DEPTH - 1));

    gat_bram_wr_port #(
        .TOP_WIDTH (TOP_WIDTH), .DEPTH (H_DATA_DEPTH), .ADDR_W (H_DATA_ADDR_W), .CNT_W (CNT_W)
    ) u_wr_hdata (
        .phase_en_i (ph_en_s[PH_HDATA]), .wr_i (wr_s), .cnt_i (cnt_q), .data_i (s_data),
        .din_o (h_data_bram_din), .ena_o (h_data_bram_ena), .wea_o (h_data_bram_wea),
        .addra_o (h_data_bram_addra), .last_o (wr_last_s[PH_HDATA])
    );

    gat_bram_wr_port #(
        .TOP_WIDTH (TOP_WIDTH), .DEPTH (NODE_INFO_DEPTH), .ADDR_W (NODE_INFO_ADDR_W), .CNT_W (CNT_W)
    ) u_wr_ninfo (
        .phase_en_i (ph_en_s[PH_NINFO]), .wr_i (wr_s), .cnt_i (cnt_q), .data_i (s_data),
        .din_o (h_node_info_bram_din), .ena_o (h_node_info_bram_ena), .wea_o (h_node_info_bram_wea),
        .addra_o (h_node_info_bram_addra), .last_o (wr_last_s[PH_NINFO])
    );

    gat_bram_wr_port #(
        .TOP_WIDTH (TOP_WIDTH), .DEPTH (WEIGHT_DEPTH), .ADDR_W (WEIGHT_ADDR_W), .CNT_W (CNT_W)
    ) u_wr_wgt (
        .phase_en_i (ph_en_s[PH_WGT]), .wr_i (wr_s), .cnt_i (cnt_q), .data_i (s_data),
        .din_o (wgt_bram_din), .ena_o (wgt_bram_ena), .wea_o (wgt_bram_wea),
        .addra_o (wgt_bram_addra), .last_o (wr_last_s[PH_WGT])
    );

    gat_bram_wr_port #(
        .TOP_WIDTH (TOP_WIDTH), .DEPTH (SUBGRAPH_IDX_DEPTH), .ADDR_W (SUBGRAPH_IDX_ADDR_W), .CNT_W (CNT_W)
    ) u_wr_subg (
        .phase_en_i (ph_en_s[PH_SUBG]), .wr_i (wr_s), .cnt_i (cnt_q), .data_i (s_data),
        .din_o (subgraph_bram_din), .ena_o (subgraph_bram_ena), .wea_o (subgraph_bram_wea),
        .addra_o (subgraph_bram_addra), .last_o (wr_last_s[PH_SUBG])
    );

    // Sequencer next-state, counters, done flags and result register.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rcnt_d     = rcnt_q;
        done_d     = done_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        run_done_d = 1'b0;
        if (cfg_abort) begin
            state_d   = ST_IDLE;
            cnt_d     = {CNT_W{1'b0}};
            rcnt_d    = {CNT_W{1'b0}};
            done_d    = {NUM_DONE{1'b0}};
            m_data_d  = {TOP_WIDTH{1'b0}};
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state_d = ST_LD_HDATA;
                        done_d  = {NUM_DONE{1'b0}};
                        cnt_d   = {CNT_W{1'b0}};
                        rcnt_d  = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LD_HDATA: begin
                    if (wr_last_s[PH_HDATA]) begin
                        cnt_d            = {CNT_W{1'b0}};
                        done_d[PH_HDATA] = 1'b1;
                        state_d          = ST_LD_NINFO;
                    end else if (wr_s) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_LD_NINFO: begin
                    if (wr_last_s[PH_NINFO]) begin
                        cnt_d            = {CNT_W{1'b0}};
                        done_d[PH_NINFO] = 1'b1;
                        state_d          = ST_LD_WGT;
                    end else if (wr_s) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_LD_WGT: begin
                    if (wr_last_s[PH_WGT]) begin
                        cnt_d          = {CNT_W{1'b0}};
                        done_d[PH_WGT] = 1'b1;
                        state_d        = ST_LD_SUBG;
                    end else if (wr_s) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_LD_SUBG: begin
                    if (wr_last_s[PH_SUBG]) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_WAIT_GAT;
                    end else if (wr_s) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                // Only a fresh 0->1 of gat_ready counts; a level left high from before is stale.
                ST_WAIT_GAT: begin
                    if (gat_rise_s) begin
                        state_d = ST_RD_ADDR;
                    end else begin
                        state_d = ST_WAIT_GAT;
                    end
                end
                ST_RD_ADDR: begin
                    state_d = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    state_d   = ST_RD_OUT;
                    m_data_d  = feat_bram_dout;
                    m_valid_d = 1'b1;
                    m_last_d  = rd_last_s;
                end
                ST_RD_OUT: begin
                    if (m_ready) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        if (m_last_q) begin
                            state_d    = ST_IDLE;
                            rcnt_d     = {CNT_W{1'b0}};
                            run_done_d = 1'b1;
                        end else begin
                            state_d = ST_RD_ADDR;
                            rcnt_d  = rcnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_RD_OUT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            rcnt_q      <= {CNT_W{1'b0}};
            done_q      <= {NUM_DONE{1'b0}};
            gat_ready_q <= 1'b0;
            m_data_q    <= {TOP_WIDTH{1'b0}};
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            run_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            done_q      <= done_d;
            gat_ready_q <= gat_ready;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            run_done_q  <= run_done_d;
        end
    end

    assign h_data_bram_load_done      = done_q[PH_HDATA];
    assign h_node_info_bram_load_done = done_q[PH_NINFO];
    assign wgt_bram_load_done         = done_q[PH_WGT];
    assign feat_bram_addrb            = {rcnt_q[NEW_FEATURE_ADDR_W-1:0], 2'b00};
    assign m_data                     = m_data_q;
    assign m_valid                    = m_valid_q;
    assign m_last                     = m_last_q;
    assign busy                       = (state_q != ST_IDLE);
    assign run_done                   = run_done_q;

endmodule
